// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx: read-side half of an asynchronous FIFO pointer crossing.
// Synchronises the foreign Gray write pointer, owns the read pointer and reports FIFO status.
module gray_ptr_rx #(
  parameter int W      = 5,
  parameter int SYNC_N = 2
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [W-1:0] wr_ptr_gray_i,
  input  logic         pop_i,
  output logic         pop_ack_o,
  output logic         empty_o,
  output logic [W-1:0] occupancy_o,
  output logic [W-1:0] rd_ptr_bin_o,
  output logic [W-1:0] rd_ptr_gray_o,
  output logic [W-1:0] wr_ptr_bin_o,
  output logic         err_ovf_o,
  output logic         err_udf_o
);

  localparam logic [W:0] DEPTH = (W+1)'(1) << (W-1);

  logic [W-1:0] sync_q [SYNC_N];
  logic [W-1:0] wr_bin_dec;
  logic [W-1:0] wr_bin_q;
  logic [W-1:0] rd_bin_q;
  logic [W-1:0] rd_gray_q;
  logic [W-1:0] rd_bin_nxt;
  logic [W-1:0] occ;
  logic         empty;
  logic         pop_ack;
  logic         ovf_q;
  logic         udf_q;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The first stage samples the raw foreign pointer with no logic in front of it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < SYNC_N; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wr_ptr_gray_i;
      for (int i = 1; i < SYNC_N; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_comb begin
    wr_bin_dec = gray2bin(sync_q[SYNC_N-1]);
  end

  assign occ        = wr_bin_q - rd_bin_q;
  assign empty      = (occ == '0);
  assign pop_ack    = pop_i & ~empty;
  assign rd_bin_nxt = rd_bin_q + W'(1);

  // Gray read pointer is loaded from the next binary value so both move on the same edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_bin_q  <= '0;
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
    end else begin
      wr_bin_q <= wr_bin_dec;
      if (pop_ack) begin
        rd_bin_q  <= rd_bin_nxt;
        rd_gray_q <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if ({1'b0, occ} > DEPTH) begin
        ovf_q <= 1'b1;
      end
      if (pop_i && empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign pop_ack_o     = pop_ack;
  assign empty_o       = empty;
  assign occupancy_o   = occ;
  assign rd_ptr_bin_o  = rd_bin_q;
  assign rd_ptr_gray_o = rd_gray_q;
  assign wr_ptr_bin_o  = wr_bin_q;
  assign err_ovf_o     = ovf_q;
  assign err_udf_o     = udf_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb_gray_ptr_rx: randomized and directed checks of gray_ptr_rx against a pointer-arithmetic model.
// The model tracks integer pointers and a plain delay queue for the crossing latency.
module tb_gray_ptr_rx;

  localparam int W      = 5;
  localparam int SYNC_N = 2;
  localparam int MASK   = (1 << W) - 1;
  localparam int DEPTH  = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         arst_n;
  logic [W-1:0] wr_ptr_gray_i;
  logic         pop_i;
  logic         pop_ack_o;
  logic         empty_o;
  logic [W-1:0] occupancy_o;
  logic [W-1:0] rd_ptr_bin_o;
  logic [W-1:0] rd_ptr_gray_o;
  logic [W-1:0] wr_ptr_bin_o;
  logic         err_ovf_o;
  logic         err_udf_o;

  gray_ptr_rx #(.W(W), .SYNC_N(SYNC_N)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .wr_ptr_gray_i(wr_ptr_gray_i),
    .pop_i        (pop_i),
    .pop_ack_o    (pop_ack_o),
    .empty_o      (empty_o),
    .occupancy_o  (occupancy_o),
    .rd_ptr_bin_o (rd_ptr_bin_o),
    .rd_ptr_gray_o(rd_ptr_gray_o),
    .wr_ptr_bin_o (wr_ptr_bin_o),
    .err_ovf_o    (err_ovf_o),
    .err_udf_o    (err_udf_o)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  int wrM, rdM, wrBinM;
  bit udfM, ovfM;
  int pipeQ[$];

  int prevGray, prevRd;
  bit prevValid;
  int grayBad;
  int maxOcc;
  bit sawWrap;
  int rdSave;

  function automatic int enc(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  function automatic int modelOcc();
    return (wrBinM - rdM) & MASK;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    rdM       = 0;
    wrBinM    = 0;
    udfM      = 1'b0;
    ovfM      = 1'b0;
    prevValid = 1'b0;
    pipeQ.delete();
    for (int i = 0; i < SYNC_N; i++) pipeQ.push_back(0);
  endtask

  // Called at a falling edge: drive inputs, compare against the model, advance the model one edge.
  task automatic applyStimulus(input bit incWr, input bit popReq);
    int  occM;
    bit  emptyM, ackM;
    wrM           = (wrM + int'(incWr)) & MASK;
    wr_ptr_gray_i = W'(enc(wrM));
    pop_i         = popReq;
    #1;
    occM   = modelOcc();
    emptyM = (occM == 0);
    ackM   = popReq && !emptyM;
    checkOutput("pop_ack", 32'(pop_ack_o), 32'(ackM));
    checkOutput("empty", 32'(empty_o), 32'(emptyM));
    checkOutput("occupancy", 32'(occupancy_o), 32'(occM));
    checkOutput("rd_bin", 32'(rd_ptr_bin_o), 32'(rdM));
    checkOutput("rd_gray", 32'(rd_ptr_gray_o), 32'(enc(rdM)));
    checkOutput("wr_bin", 32'(wr_ptr_bin_o), 32'(wrBinM));
    checkOutput("err_ovf", 32'(err_ovf_o), 32'(ovfM));
    checkOutput("err_udf", 32'(err_udf_o), 32'(udfM));
    if (prevValid) begin
      if ($countones(W'(prevGray) ^ rd_ptr_gray_o) > 1) grayBad++;
      if (prevRd == MASK && rd_ptr_bin_o == 0 && prevGray == DEPTH && rd_ptr_gray_o == 0) sawWrap = 1'b1;
    end
    prevGray  = int'(rd_ptr_gray_o);
    prevRd    = int'(rd_ptr_bin_o);
    prevValid = 1'b1;
    if (int'(occupancy_o) > maxOcc) maxOcc = int'(occupancy_o);
    if (popReq && emptyM) udfM = 1'b1;
    if (occM > DEPTH) ovfM = 1'b1;
    if (ackM) rdM = (rdM + 1) & MASK;
    pipeQ.push_back(wrM);
    wrBinM = pipeQ.pop_front();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH; i++) applyStimulus(1'b0, modelOcc() != 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pop_ack"}, 32'(pop_ack_o), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty_o), 32'd1);
    checkOutput({tag, "_occ"}, 32'(occupancy_o), 32'd0);
    checkOutput({tag, "_rd_bin"}, 32'(rd_ptr_bin_o), 32'd0);
    checkOutput({tag, "_rd_gray"}, 32'(rd_ptr_gray_o), 32'd0);
    checkOutput({tag, "_wr_bin"}, 32'(wr_ptr_bin_o), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(err_ovf_o), 32'd0);
    checkOutput({tag, "_udf"}, 32'(err_udf_o), 32'd0);
  endtask

  initial begin
    grayBad = 0;
    maxOcc  = 0;
    sawWrap = 1'b0;
    arst_n  = 1'b1;
    pop_i   = 1'b0;
    wr_ptr_gray_i = '0;
    #1;
    // Reset held while the foreign side already shows binary 4.
    arst_n        = 1'b0;
    wrM           = 4;
    wr_ptr_gray_i = 5'b00110;
    resetModel();
    #20;
    checkResetValues("reset");
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < SYNC_N + 1; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("reset_wr_bin_after", 32'(wr_ptr_bin_o), 32'd4);
    checkOutput("reset_occ_after", 32'(occupancy_o), 32'd4);
    checkOutput("reset_empty_after", 32'(empty_o), 32'd0);

    drain();
    maxOcc = 0;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, modelOcc() != 0);
    for (int i = 0; i < 2 * (1 << W) - 40; i++) applyStimulus(1'b1, modelOcc() != 0);
    checkOutput("wrap_max_occ_le2", 32'(maxOcc <= 2), 32'd1);
    checkOutput("wrap_seen", 32'(sawWrap), 32'd1);
    checkOutput("wrap_gray_single_bit", 32'(grayBad), 32'd0);
    checkOutput("wrap_no_udf", 32'(err_udf_o), 32'd0);
    checkOutput("wrap_no_ovf", 32'(err_ovf_o), 32'd0);

    drain();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("simul_occ_before", 32'(occupancy_o), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("simul_occ_after", 32'(occupancy_o), 32'd1);

    drain();
    rdSave = rdM;
    checkOutput("udf_clear_before", 32'(err_udf_o), 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("udf_set", 32'(err_udf_o), 32'd1);
    checkOutput("udf_rd_unchanged", 32'(rd_ptr_bin_o), 32'(rdSave));
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("udf_held", 32'(err_udf_o), 32'd1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1) && (((wrM - rdM) & MASK) < DEPTH),
                    $urandom_range(0, 1) == 1);
    end
    checkOutput("random_gray_single_bit", 32'(grayBad), 32'd0);
    checkOutput("random_no_ovf", 32'(err_ovf_o), 32'd0);

    drain();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < SYNC_N + 1; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("async_occ_before", 32'(occupancy_o), 32'd7);
    #2;
    arst_n = 1'b0;
    #1;
    checkResetValues("async");
    wrM           = 0;
    wr_ptr_gray_i = '0;
    resetModel();
    @(negedge clk);
    arst_n = 1'b1;

    wrM = 17 - 0;
    wrM = 16;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < SYNC_N; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("ovf_occ", 32'(occupancy_o), 32'd17);
    checkOutput("ovf_not_yet", 32'(err_ovf_o), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ovf_set", 32'(err_ovf_o), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("ovf_held", 32'(err_ovf_o), 32'd1);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
